// File: rtl/seq_nonrestoring_divider_if.sv
// ---------------------------------------------------------------------------------------------
// seq_nonrestoring_divider_if
//   Operand/result handshake bundle for the sequential non-restoring divider.
//
//   Signals (W = operand width):
//     in_valid   requester -> divider   dividend/divisor valid
//     in_ready   divider   -> requester divider idle, operand pair can be accepted
//     dividend   requester -> divider   unsigned dividend, W bits
//     divisor    requester -> divider   unsigned divisor, W bits
//     out_valid  divider   -> requester quotient/remainder valid
//     out_ready  requester -> divider   requester takes the result
//     quotient   divider   -> requester unsigned quotient, W bits
//     remainder  divider   -> requester unsigned remainder, W bits
//     div_zero   divider   -> requester divisor was zero (only with early zero exit built in)
//
//   Modports:
//     master  the side issuing divisions and consuming results
//     slave   the divider itself
// ---------------------------------------------------------------------------------------------
interface seq_nonrestoring_divider_if #(
   parameter int unsigned W = 8
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   modport master (
      output in_valid,
      input  in_ready,
      output dividend,
      output divisor,
      input  out_valid,
      output out_ready,
      input  quotient,
      input  remainder,
      input  div_zero
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  dividend,
      input  divisor,
      output out_valid,
      input  out_ready,
      output quotient,
      output remainder,
      output div_zero
   );

endinterface

// File: rtl/seq_nonrestoring_divider.sv
// ---------------------------------------------------------------------------------------------
// seq_nonrestoring_divider
//   Iterative unsigned radix-2 non-restoring divider. One (W+1)-bit add/subtract per cycle on
//   the partial remainder: subtract the divisor while the remainder is non-negative, add it back
//   while it is negative. A final correction step makes the remainder non-negative. One division
//   is in flight at a time; valid/ready handshakes on both the operand and the result side.
//
//   Parameters:
//     W          operand/quotient width (W >= 2); the remainder datapath is W+1 bits
//
//   Ports:
//     clk        single clock, all state changes on its rising edge
//     rst_n      synchronous active-low reset; aborts any division in progress
//     bus        seq_nonrestoring_divider_if.slave: in_valid/in_ready/dividend/divisor on the
//                operand side, out_valid/out_ready/quotient/remainder/div_zero on the result side
//
//   Timing (W = 8):
//     accept edge -> 8 iteration edges (CALC) -> 1 correction edge (CORR) -> DONE.
//     out_valid is seen high at the 10th rising edge after the accepting edge, and with out_ready
//     held high a new pair can be accepted every 11 cycles.
//
//   Build option:
//     DIV_ZERO_DET_EN  when defined, a zero divisor is recognised at accept and the divider goes
//                      straight to DONE with quotient = all ones, remainder = dividend and
//                      div_zero = 1. When undefined there is no detection logic, div_zero is tied
//                      low, and a zero divisor simply runs the full iteration (which naturally
//                      yields the same quotient/remainder).
// ---------------------------------------------------------------------------------------------
module seq_nonrestoring_divider #(
   parameter int unsigned W = 8
) (
   input logic                       clk,
   input logic                       rst_n,
   seq_nonrestoring_divider_if.slave bus
);

   // ------------------------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------------------------
   localparam int unsigned     CntW    = (W > 1) ? $clog2(W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StCorr = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // ------------------------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------------------------
   logic [1:0]      state_q, state_d;
   logic [W:0]      rem_part_q, rem_part_d;   // signed partial remainder (two's complement)
   logic [W-1:0]    quo_part_q, quo_part_d;   // dividend shifting out, quotient bits shifting in
   logic [W-1:0]    dvsr_q, dvsr_d;           // latched divisor
   logic [CntW-1:0] cnt_q, cnt_d;             // iteration counter
   logic [W-1:0]    quot_q, quot_d;           // result registers, held until next result
   logic [W-1:0]    rem_q, rem_d;

`ifdef DIV_ZERO_DET_EN
   logic            dz_q, dz_d;
   logic            zero_dvsr;
`endif

   // ------------------------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------------------------
   logic [W:0]   dvsr_ext;
   logic [W:0]   rem_shift;
   logic [W:0]   rem_step;
   logic [W:0]   rem_fix;
   logic [W-1:0] quo_step;

   assign dvsr_ext  = {1'b0, dvsr_q};

   // Shift {R,Q} left by one: the MSB of the dividend register enters the remainder.
   assign rem_shift = {rem_part_q[W-1:0], quo_part_q[W-1]};

   // Sign of the previous remainder selects the operation; arithmetic wraps modulo 2^(W+1).
   assign rem_step  = rem_part_q[W] ? (rem_shift + dvsr_ext) : (rem_shift - dvsr_ext);

   // New quotient bit is 1 when the new partial remainder is non-negative.
   assign quo_step  = {quo_part_q[W-2:0], ~rem_step[W]};

   // A negative final remainder is restored by adding the divisor back once.
   assign rem_fix   = rem_part_q[W] ? (rem_part_q + dvsr_ext) : rem_part_q;

`ifdef DIV_ZERO_DET_EN
   assign zero_dvsr = (bus.divisor == '0);
`endif

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rem_part_d = rem_part_q;
      quo_part_d = quo_part_q;
      dvsr_d     = dvsr_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
`ifdef DIV_ZERO_DET_EN
      dz_d       = dz_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               dvsr_d     = bus.divisor;
               quo_part_d = bus.dividend;
               rem_part_d = '0;
               cnt_d      = '0;
               state_d    = StCalc;
`ifdef DIV_ZERO_DET_EN
               // Early exit: publish the same values the iteration would produce.
               if (zero_dvsr) begin
                  quot_d  = '1;
                  rem_d   = bus.dividend;
                  dz_d    = 1'b1;
                  state_d = StDone;
               end
`endif
            end
         end

         StCalc: begin
            rem_part_d = rem_step;
            quo_part_d = quo_step;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StCorr;
            end
         end

         StCorr: begin
            quot_d  = quo_part_q;
            rem_d   = rem_fix[W-1:0];
`ifdef DIV_ZERO_DET_EN
            dz_d    = 1'b0;
`endif
            state_d = StDone;
         end

         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rem_part_q <= '0;
         quo_part_q <= '0;
         dvsr_q     <= '0;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         rem_part_q <= rem_part_d;
         quo_part_q <= quo_part_d;
         dvsr_q     <= dvsr_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
      end
   end

`ifdef DIV_ZERO_DET_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dz_q <= 1'b0;
      end else begin
         dz_q <= dz_d;
      end
   end
`endif

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;

`ifdef DIV_ZERO_DET_EN
   assign bus.div_zero  = dz_q;
`else
   assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// ---------------------------------------------------------------------------------------------
// tb_seq_nonrestoring_divider
//   Directed vector table plus hand-written sequences (backpressure, mid-division reset) and a
//   block of random operand pairs checked against the / and % operators.
//   Latency is counted as the number of rising edges after the accepting edge up to and
//   including the first edge at which out_valid is high.
// ---------------------------------------------------------------------------------------------
module tb_seq_nonrestoring_divider;

   localparam int unsigned W = 8;

`ifdef DIV_ZERO_DET_EN
   localparam logic ZeroDz  = 1'b1;
   localparam int   ZeroLat = 1;
`else
   localparam logic ZeroDz  = 1'b0;
   localparam int   ZeroLat = 10;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_nonrestoring_divider_if #(.W(W)) bus ();

   seq_nonrestoring_divider #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One division; inputs driven and outputs sampled at the falling edge.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int stall,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output int lat);
      int k;
      k = 0;
      while (!bus.in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = (stall == 0);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.dividend  = 8'($urandom);
      bus.divisor   = 8'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      q  = bus.quotient;
      r  = bus.remainder;
      dz = bus.div_zero;
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;  // must be ignored while a result is pending
         bus.dividend = 8'd3;
         bus.divisor  = 8'd1;
         @(negedge clk);
         check("stall_hold", {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder,
                              bus.div_zero}, {1'b1, 1'b0, q, r, dz});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("release_idle", {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder},
            {1'b0, 1'b1, q, r});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q, r, ea, eb;
      logic       dz;
      int         lat;

      vecs[0] = '{a: 8'd200, b: 8'd13,  q: 8'd15,   r: 8'd5,    dz: 1'b0,   lat: 10};
      vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255,  r: 8'd0,    dz: 1'b0,   lat: 10};
      vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,    r: 8'd5,    dz: 1'b0,   lat: 10};
      vecs[3] = '{a: 8'd0,   b: 8'd7,   q: 8'd0,    r: 8'd0,    dz: 1'b0,   lat: 10};
      vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,    r: 8'd0,    dz: 1'b0,   lat: 10};
      vecs[5] = '{a: 8'h64,  b: 8'd0,   q: 8'hFF,   r: 8'h64,   dz: ZeroDz, lat: ZeroLat};
      vecs[6] = '{a: 8'd100, b: 8'd7,   q: 8'd14,   r: 8'd2,    dz: 1'b0,   lat: 10};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.dividend  = '0;
      bus.divisor   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_state", {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder,
                            bus.div_zero}, {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      foreach (vecs[i]) begin
         run_div(vecs[i].a, vecs[i].b, 0, q, r, dz, lat);
         check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
         check($sformatf("vec%0d_div_zero", i), 32'(dz), 32'(vecs[i].dz));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Backpressure: result held for 5 cycles, new in_valid ignored
      run_div(8'd200, 8'd13, 5, q, r, dz, lat);
      check("stall_quotient", 32'(q), 32'd15);
      check("stall_remainder", 32'(r), 32'd5);
      check("stall_latency", 32'(lat), 32'd10);

      // Reset during CALC (4th cycle after accept) aborts the division
      bus.dividend = 8'd200;
      bus.divisor  = 8'd13;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midcalc_reset", {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder,
                              bus.div_zero}, {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});
      repeat (12) @(negedge clk);
      check("no_result_after_reset", {bus.in_ready, bus.out_valid}, {1'b1, 1'b0});
      run_div(8'd100, 8'd7, 0, q, r, dz, lat);
      check("post_reset_quotient", 32'(q), 32'd14);
      check("post_reset_remainder", 32'(r), 32'd2);

      // Random nonzero-divisor pairs with random backpressure
      for (int n = 0; n < 2000; n++) begin
         ea = 8'($urandom_range(0, 255));
         eb = 8'($urandom_range(1, 255));
         run_div(ea, eb, int'($urandom_range(0, 2)), q, r, dz, lat);
         check($sformatf("rand%0d_%0d/%0d_quotient", n, ea, eb), 32'(q), 32'(ea / eb));
         check($sformatf("rand%0d_%0d/%0d_remainder", n, ea, eb), 32'(r), 32'(ea % eb));
         check($sformatf("rand%0d_latency", n), 32'(lat), 32'd10);
         check($sformatf("rand%0d_div_zero", n), 32'(dz), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
